// File: rtl/seq_hit_window.sv
// Counts detector match pulses over back-to-back programmable windows and
// hands each window result to a reader through a one-entry valid/ready buffer.
module seq_hit_window #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hit,
  input  logic             enable,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] thresh,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_sat,
  output logic             rpt_alarm,
  output logic             dropped
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t r_state, w_state_nxt;

  logic [WIN_W-1:0] r_win_len, w_win_len_nxt;
  logic [CNT_W-1:0] r_thresh, w_thresh_nxt;
  logic [WIN_W-1:0] r_cyc_cnt, w_cyc_cnt_nxt;
  logic [CNT_W-1:0] r_hit_cnt, w_hit_cnt_nxt;
  logic             r_sat, w_sat_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_rpt_valid, w_rpt_valid_nxt;
  logic [CNT_W-1:0] r_rpt_count, w_rpt_count_nxt;
  logic             r_rpt_sat, w_rpt_sat_nxt;
  logic             r_rpt_alarm, w_rpt_alarm_nxt;
  logic             r_dropped, w_dropped_nxt;

  // Count including this cycle's hit; it is what a window end reports.
  logic [CNT_W-1:0] w_hit_sum;
  logic             w_sat_sum;
  logic             w_alarm;
  logic             w_win_end;
  logic             w_rpt_free;
  logic             w_restart;

  assign w_hit_sum  = (hit && (r_hit_cnt != CNT_MAX)) ? r_hit_cnt + CNT_W'(1) : r_hit_cnt;
  assign w_sat_sum  = r_sat | (hit & (r_hit_cnt == CNT_MAX));
  assign w_alarm    = (w_hit_sum >= r_thresh);
  assign w_win_end  = (r_cyc_cnt == (r_win_len - WIN_W'(1)));
  assign w_rpt_free = ~r_rpt_valid | rpt_ready;
  assign w_restart  = enable & (win_len != '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state, counter and report-buffer logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_win_len_nxt   = r_win_len;
    w_thresh_nxt    = r_thresh;
    w_cyc_cnt_nxt   = r_cyc_cnt;
    w_hit_cnt_nxt   = r_hit_cnt;
    w_sat_nxt       = r_sat;
    w_rpt_valid_nxt = r_rpt_valid;
    w_rpt_count_nxt = r_rpt_count;
    w_rpt_sat_nxt   = r_rpt_sat;
    w_rpt_alarm_nxt = r_rpt_alarm;
    w_dropped_nxt   = 1'b0;

    if (r_rpt_valid && rpt_ready) begin
      w_rpt_valid_nxt = 1'b0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_restart) begin
          w_win_len_nxt = win_len;
          w_thresh_nxt  = thresh;
          w_cyc_cnt_nxt = '0;
          w_hit_cnt_nxt = '0;
          w_sat_nxt     = 1'b0;
          w_state_nxt   = ST_RUN;
        end
      end
      ST_RUN: begin
        w_cyc_cnt_nxt = r_cyc_cnt + WIN_W'(1);
        w_hit_cnt_nxt = w_hit_sum;
        w_sat_nxt     = w_sat_sum;
        if (w_win_end) begin
          // A load in the same cycle as an accept keeps the buffer full.
          if (w_rpt_free) begin
            w_rpt_valid_nxt = 1'b1;
            w_rpt_count_nxt = w_hit_sum;
            w_rpt_sat_nxt   = w_sat_sum;
            w_rpt_alarm_nxt = w_alarm;
          end else begin
            w_dropped_nxt = 1'b1;
          end
          if (w_restart) begin
            w_win_len_nxt = win_len;
            w_thresh_nxt  = thresh;
            w_cyc_cnt_nxt = '0;
            w_hit_cnt_nxt = '0;
            w_sat_nxt     = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (!enable) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_busy_nxt = (w_state_nxt == ST_RUN);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_len   <= '0;
      r_thresh    <= '0;
      r_cyc_cnt   <= '0;
      r_hit_cnt   <= '0;
      r_sat       <= 1'b0;
      r_busy      <= 1'b0;
      r_rpt_valid <= 1'b0;
      r_rpt_count <= '0;
      r_rpt_sat   <= 1'b0;
      r_rpt_alarm <= 1'b0;
      r_dropped   <= 1'b0;
    end else begin
      r_win_len   <= w_win_len_nxt;
      r_thresh    <= w_thresh_nxt;
      r_cyc_cnt   <= w_cyc_cnt_nxt;
      r_hit_cnt   <= w_hit_cnt_nxt;
      r_sat       <= w_sat_nxt;
      r_busy      <= w_busy_nxt;
      r_rpt_valid <= w_rpt_valid_nxt;
      r_rpt_count <= w_rpt_count_nxt;
      r_rpt_sat   <= w_rpt_sat_nxt;
      r_rpt_alarm <= w_rpt_alarm_nxt;
      r_dropped   <= w_dropped_nxt;
    end
  end

  assign busy      = r_busy;
  assign rpt_valid = r_rpt_valid;
  assign rpt_count = r_rpt_count;
  assign rpt_sat   = r_rpt_sat;
  assign rpt_alarm = r_rpt_alarm;
  assign dropped   = r_dropped;

endmodule

// File: tb/tb_seq_hit_window.sv
// Bench for seq_hit_window: directed scenarios plus random traffic, all
// checked against a window-level reference model.
module tb_seq_hit_window;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned WIN_W = 16;
  localparam int MAXC = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             hit;
  logic             enable;
  logic [WIN_W-1:0] win_len;
  logic [CNT_W-1:0] thresh;
  logic             busy;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_count;
  logic             rpt_sat;
  logic             rpt_alarm;
  logic             dropped;

  always #5 clk = ~clk;

  seq_hit_window #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .hit       (hit),
    .enable    (enable),
    .win_len   (win_len),
    .thresh    (thresh),
    .busy      (busy),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_count (rpt_count),
    .rpt_sat   (rpt_sat),
    .rpt_alarm (rpt_alarm),
    .dropped   (dropped)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: window position, raw (unsaturated) hit total, report slot.
  int m_run, m_pos, m_len, m_thr, m_cnt;
  int m_valid, m_count, m_sat, m_alarm, m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_len = 0; m_thr = 0; m_cnt = 0;
    m_valid = 0; m_count = 0; m_sat = 0; m_alarm = 0; m_drop = 0;
  endtask

  task automatic model_step(input int h, input int e, input int wl, input int th, input int rdy);
    int prev_valid;
    int loaded;
    prev_valid = m_valid;
    loaded = 0;
    m_drop = 0;
    if (m_run == 0) begin
      if (e != 0 && wl != 0) begin
        m_run = 1; m_len = wl; m_thr = th; m_pos = 0; m_cnt = 0;
      end
    end else begin
      if (h != 0) m_cnt++;
      if (m_pos == m_len - 1) begin
        if (prev_valid == 0 || rdy != 0) begin
          m_count = (m_cnt > MAXC) ? MAXC : m_cnt;
          m_sat   = (m_cnt > MAXC) ? 1 : 0;
          m_alarm = (m_count >= m_thr) ? 1 : 0;
          loaded  = 1;
        end else begin
          m_drop = 1;
        end
        if (e != 0 && wl != 0) begin
          m_len = wl; m_thr = th; m_pos = 0; m_cnt = 0;
        end else begin
          m_run = 0;
        end
      end else if (e == 0) begin
        m_run = 0;
      end else begin
        m_pos++;
      end
    end
    if (loaded != 0) m_valid = 1;
    else if (prev_valid != 0 && rdy != 0) m_valid = 0;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".busy"},      32'(busy),      32'(m_run));
    chk({tag, ".rpt_valid"}, 32'(rpt_valid), 32'(m_valid));
    chk({tag, ".rpt_count"}, 32'(rpt_count), 32'(m_count));
    chk({tag, ".rpt_sat"},   32'(rpt_sat),   32'(m_sat));
    chk({tag, ".rpt_alarm"}, 32'(rpt_alarm), 32'(m_alarm));
    chk({tag, ".dropped"},   32'(dropped),   32'(m_drop));
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic cycle(input int h, input int e, input int wl, input int th, input int rdy);
    hit       = 1'(h);
    enable    = 1'(e);
    win_len   = WIN_W'(wl);
    thresh    = CNT_W'(th);
    rpt_ready = 1'(rdy);
    @(posedge clk);
    model_step(h, e, wl, th, rdy);
    @(negedge clk);
    compare_all("cyc");
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".busy"},      32'(busy),      32'd0);
    chk({tag, ".rpt_valid"}, 32'(rpt_valid), 32'd0);
    chk({tag, ".rpt_count"}, 32'(rpt_count), 32'd0);
    chk({tag, ".rpt_sat"},   32'(rpt_sat),   32'd0);
    chk({tag, ".rpt_alarm"}, 32'(rpt_alarm), 32'd0);
    chk({tag, ".dropped"},   32'(dropped),   32'd0);
  endtask

  initial begin
    rst = 1'b1; hit = 1'b0; enable = 1'b0; win_len = '0; thresh = '0; rpt_ready = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic window: hits on RUN cycles 0,2,4,7 of an 8-cycle window.
    cycle(0, 1, 8, 3, 1);
    for (int i = 0; i < 8; i++) cycle((i == 0 || i == 2 || i == 4 || i == 7) ? 1 : 0, 1, 8, 3, 1);
    chk("basic.valid", 32'(rpt_valid), 32'd1);
    chk("basic.count", 32'(rpt_count), 32'd4);
    chk("basic.alarm", 32'(rpt_alarm), 32'd1);
    chk("basic.sat",   32'(rpt_sat),   32'd0);
    chk("basic.busy",  32'(busy),      32'd1);
    cycle(0, 1, 8, 3, 1);
    chk("basic.nogap", 32'(busy), 32'd1);
    cycle(0, 0, 8, 3, 1);

    // Saturation over a 300-cycle window with hit held high.
    cycle(0, 1, 300, 10, 1);
    for (int i = 0; i < 300; i++) cycle(1, (i == 299) ? 0 : 1, 300, 10, 1);
    chk("sat.count", 32'(rpt_count), 32'd255);
    chk("sat.sat",   32'(rpt_sat),   32'd1);
    chk("sat.busy",  32'(busy),      32'd0);
    cycle(0, 0, 0, 0, 1);

    // Full buffer: second window result is dropped.
    cycle(0, 1, 4, 0, 0);
    for (int i = 0; i < 4; i++) cycle((i == 1) ? 1 : 0, 1, 4, 0, 0);
    chk("drop.first", 32'(rpt_count), 32'd1);
    for (int i = 0; i < 4; i++) cycle((i == 0 || i == 3) ? 1 : 0, (i == 3) ? 0 : 1, 4, 0, 0);
    chk("drop.pulse", 32'(dropped),   32'd1);
    chk("drop.held",  32'(rpt_count), 32'd1);
    cycle(0, 0, 0, 0, 1);
    chk("drop.once",  32'(dropped),   32'd0);
    chk("drop.read",  32'(rpt_valid), 32'd0);

    // Window end coinciding with a read: load wins.
    cycle(0, 1, 2, 1, 0);
    cycle(1, 1, 2, 1, 0);
    cycle(1, 1, 2, 1, 0);
    cycle(0, 1, 2, 1, 0);
    cycle(1, 0, 2, 1, 1);
    chk("coin.valid", 32'(rpt_valid), 32'd1);
    chk("coin.count", 32'(rpt_count), 32'd1);
    chk("coin.drop",  32'(dropped),   32'd0);

    // Abort at RUN cycle 3 of a 10-cycle window, then win_len=0 stays idle.
    cycle(0, 0, 0, 0, 1);
    cycle(0, 1, 10, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 10, 0, 0);
    cycle(1, 0, 10, 0, 0);
    chk("abort.busy",  32'(busy),      32'd0);
    chk("abort.valid", 32'(rpt_valid), 32'd0);
    chk("abort.drop",  32'(dropped),   32'd0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 5, 1);
    chk("wl0.busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-RUN with a pending report.
    cycle(0, 1, 3, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 3, 0, 0);
    chk("rstmid.pre", 32'(rpt_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all_zero("rstmid");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(1, 0, 5, 0, 1);
    chk("rstmid.idle", 32'(busy), 32'd0);

    // Random traffic.
    begin
      int wl, th, e;
      wl = 5; th = 2; e = 1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 15) == 0) wl = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 12));
        if ($urandom_range(0, 15) == 0) th = int'($urandom_range(0, 8));
        e = ($urandom_range(0, 24) == 0) ? 0 : 1;
        cycle(int'($urandom_range(0, 1)), e, wl, th, ($urandom_range(0, 2) == 0) ? 0 : 1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
